id_exe_stage: RTL

ID_EXE_STAGE -- requirements
Module: id_exe_stage

---
 rtl/id_exe_pkg.sv | 11 +
 rtl/id_exe_stage_entry.sv | 29 ++
 rtl/id_exe_stage.sv | 79 +++++++
 3 files changed

// File: rtl/id_exe_pkg.sv
// id_exe_pkg: shared constants for the ID/EX pipeline register.
// Holds default widths, the NOP encoding and the skid occupancy states.
package id_exe_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_PC_INC  = 4;
    localparam int DEF_CNT_W   = 16;
    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_e;
endpackage

// File: rtl/id_exe_stage_entry.sv
// pipe_entry_reg: one pipeline slot, a valid bit plus payload with load and clear.
// Load wins over clear; clearing drops only the valid bit so the payload holds.
module pipe_entry_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);
    logic         valid_q;
    logic [W-1:0] data_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ld_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end
    assign valid_o = valid_q;
    assign q_o     = data_q;
endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage: decode-to-execute pipeline register with optional skid entry.
// Carries instr/PC+8/operands with a valid/ready handshake, flush and a bubble counter.
module id_exe_stage
    import id_exe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int PC_INC  = DEF_PC_INC,
    parameter int SKID    = 1,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    input  logic [DATA_W-1:0]  in_rs,
    input  logic [DATA_W-1:0]  in_rt,
    input  logic [DATA_W-1:0]  in_ext,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc8,
    output logic [DATA_W-1:0]  out_rd1,
    output logic [DATA_W-1:0]  out_rd2,
    output logic [DATA_W-1:0]  out_ext,
    output logic [CNT_W-1:0]   bubble_cnt
);
    localparam int PW = INSTR_W + PC_W + 3 * DATA_W;
    logic [PW-1:0]      in_pay, main_d, main_q;
    logic               main_v, main_ld, main_clr, in_xfer, out_xfer;
    logic [INSTR_W-1:0] main_instr;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // PC+8 is formed at capture so the held payload is already execute-ready.
    assign in_pay   = {in_instr, in_pc4 + PC_W'(PC_INC), in_rs, in_rt, in_ext};
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_v && out_ready;
    assign main_clr = flush || out_xfer;
    pipe_entry_reg #(.W(PW)) u_main (
        .clk(clk), .reset(reset), .ld_i(main_ld), .clr_i(main_clr),
        .d_i(main_d), .valid_o(main_v), .q_o(main_q)
    );
    generate
        if (SKID == 0) begin : g_single
            assign in_ready = !main_v || out_ready;
            assign main_ld  = in_xfer && !flush;
            assign main_d   = in_pay;
        end else begin : g_skid
            logic          skid_v, skid_ld;
            logic [PW-1:0] skid_q;
            occ_e          occ;
            assign occ      = skid_v ? OCC_FULL : main_v ? OCC_ONE : OCC_EMPTY;
            // Ready comes only from flop state, never from out_ready.
            assign in_ready = occ != OCC_FULL && !reset;
            assign skid_ld  = !flush && in_xfer && occ == OCC_ONE && !out_ready;
            assign main_ld  = !flush && (occ == OCC_EMPTY ? in_xfer : out_ready && (occ == OCC_FULL || in_xfer));
            assign main_d   = skid_v ? skid_q : in_pay;
            pipe_entry_reg #(.W(PW)) u_skid (
                .clk(clk), .reset(reset), .ld_i(skid_ld), .clr_i(main_clr),
                .d_i(in_pay), .valid_o(skid_v), .q_o(skid_q)
            );
        end
    endgenerate
    assign cnt_d = (out_ready && !main_v && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign {main_instr, out_pc8, out_rd1, out_rd2, out_ext} = main_q;
    assign out_valid  = main_v;
    assign out_instr  = main_v ? main_instr : INSTR_W'(NOP_INSTR);
    assign bubble_cnt = cnt_q;
endmodule
